// File: rtl/alu_serial_wide.sv
// Slice-serial wide ALU: one SLICE_WIDTH chunk per clock through a single narrow adder,
// LSB slice first, producing a DATA_WIDTH result and Z80-format flags.
module alu_serial_wide #(
  parameter int DATA_WIDTH  = 16,
  parameter int SLICE_WIDTH = 8,
  parameter int NUM_SLICES  = DATA_WIDTH / SLICE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [7:0]            flags_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [7:0]            flags_out
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_INC = 3'd4;
  localparam logic [2:0] OP_DEC = 3'd5;

  localparam int CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    busy_nxt_s;
  logic                    done_nxt_s;
  logic                    busy_r;
  logic                    done_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [DATA_WIDTH-1:0]   a_r;
  logic [DATA_WIDTH-1:0]   b_r;
  logic [DATA_WIDTH-1:0]   acc_r;
  logic [DATA_WIDTH-1:0]   result_r;
  logic [2:0]              op_r;
  logic [7:0]              flags_in_r;
  logic [7:0]              flags_out_r;
  logic                    carry_r;

  logic                    accept_s;
  logic                    last_s;
  logic [DATA_WIDTH-1:0]   b_eff_s;
  logic                    cin_s;
  logic [31:0]             base_s;
  logic [SLICE_WIDTH-1:0]  slice_a_s;
  logic [SLICE_WIDTH-1:0]  slice_b_s;
  logic [SLICE_WIDTH:0]    sum_s;
  logic                    h_carry_s;
  logic                    msb_carry_s;
  logic [DATA_WIDTH-1:0]   res_full_s;
  logic                    is_sub_s;
  logic                    keep_c_s;
  logic                    known_s;
  logic [7:0]              flags_calc_s;
  logic [DATA_WIDTH-1:0]   res_new_s;
  logic [7:0]              flags_new_s;

  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign last_s   = (state_r == ST_RUN) && (cnt_r == LAST_CNT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE and DONE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nxt_s = (cnt_r == LAST_CNT) ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt_s = start ? ST_RUN : ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_RUN:  busy_nxt_s = 1'b1;
      ST_DONE: done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Handshake output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Subtraction is a + ~b + 1; SBC folds the borrow into the carry-in
  always_comb begin
    b_eff_s = b;
    cin_s   = 1'b0;
    case (opcode)
      OP_ADD: begin b_eff_s = b;                 cin_s = 1'b0;         end
      OP_ADC: begin b_eff_s = b;                 cin_s = flags_in[0];  end
      OP_SUB: begin b_eff_s = ~b;                cin_s = 1'b1;         end
      OP_SBC: begin b_eff_s = ~b;                cin_s = ~flags_in[0]; end
      OP_INC: begin b_eff_s = {DATA_WIDTH{1'b0}}; cin_s = 1'b1;         end
      OP_DEC: begin b_eff_s = {DATA_WIDTH{1'b1}}; cin_s = 1'b0;         end
      default: begin b_eff_s = b;                cin_s = 1'b0;         end
    endcase
  end

  // One slice of the narrow adder; carries into bits are recovered as a^b^sum
  always_comb begin
    base_s      = 32'(cnt_r) * 32'(SLICE_WIDTH);
    slice_a_s   = a_r[base_s +: SLICE_WIDTH];
    slice_b_s   = b_r[base_s +: SLICE_WIDTH];
    sum_s       = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{SLICE_WIDTH{1'b0}}, carry_r};
    h_carry_s   = slice_a_s[SLICE_WIDTH-4] ^ slice_b_s[SLICE_WIDTH-4] ^ sum_s[SLICE_WIDTH-4];
    msb_carry_s = slice_a_s[SLICE_WIDTH-1] ^ slice_b_s[SLICE_WIDTH-1] ^ sum_s[SLICE_WIDTH-1];
    res_full_s  = acc_r;
    res_full_s[DATA_WIDTH-SLICE_WIDTH +: SLICE_WIDTH] = sum_s[SLICE_WIDTH-1:0];
  end

  // Final result and flags; H/PV only make sense on the top slice
  always_comb begin
    is_sub_s = 1'b0;
    keep_c_s = 1'b0;
    known_s  = 1'b1;
    case (op_r)
      OP_ADD, OP_ADC: begin is_sub_s = 1'b0; keep_c_s = 1'b0; end
      OP_SUB, OP_SBC: begin is_sub_s = 1'b1; keep_c_s = 1'b0; end
      OP_INC:         begin is_sub_s = 1'b0; keep_c_s = 1'b1; end
      OP_DEC:         begin is_sub_s = 1'b1; keep_c_s = 1'b1; end
      default:        known_s = 1'b0;
    endcase
    flags_calc_s = {res_full_s[DATA_WIDTH-1],
                    (res_full_s == {DATA_WIDTH{1'b0}}),
                    res_full_s[DATA_WIDTH-3],
                    h_carry_s ^ is_sub_s,
                    res_full_s[DATA_WIDTH-5],
                    msb_carry_s ^ sum_s[SLICE_WIDTH],
                    is_sub_s,
                    keep_c_s ? flags_in_r[0] : (sum_s[SLICE_WIDTH] ^ is_sub_s)};
    if (known_s) begin
      res_new_s   = res_full_s;
      flags_new_s = flags_calc_s;
    end else begin
      res_new_s   = a_r;
      flags_new_s = flags_in_r;
    end
  end

  // Operand latch and slice accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= {DATA_WIDTH{1'b0}};
      b_r        <= {DATA_WIDTH{1'b0}};
      acc_r      <= {DATA_WIDTH{1'b0}};
      op_r       <= 3'd0;
      flags_in_r <= 8'd0;
      carry_r    <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      a_r        <= a;
      b_r        <= b_eff_s;
      acc_r      <= {DATA_WIDTH{1'b0}};
      op_r       <= opcode;
      flags_in_r <= flags_in;
      carry_r    <= cin_s;
      cnt_r      <= {CNT_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      acc_r[base_s +: SLICE_WIDTH] <= sum_s[SLICE_WIDTH-1:0];
      carry_r <= sum_s[SLICE_WIDTH];
      cnt_r   <= last_s ? {CNT_W{1'b0}} : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Visible result/flags only change on the transition into DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= {DATA_WIDTH{1'b0}};
      flags_out_r <= 8'd0;
    end else if (last_s) begin
      result_r    <= res_new_s;
      flags_out_r <= flags_new_s;
    end else begin
      result_r    <= result_r;
      flags_out_r <= flags_out_r;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign flags_out = flags_out_r;

endmodule

// File: doc/alu_serial_wide.md
Name: alu_serial_wide

Overview:
- Multi-cycle, parametrised-width arithmetic unit for the Z80 core.
- Computes wide operations (16-bit ADD HL,rr / ADC / SBC / INC / DEC, and wider for test builds) by pushing one SLICE_WIDTH chunk per clock through a single narrow adder, LSB slice first, with the carry chained between slices.
- Sits between the instruction sequencer and the register file.
- Uses a start/busy/done handshake and produces Z80-format flags.

Parameters:
- DATA_WIDTH, 16, operand/result width; must be a multiple of SLICE_WIDTH.
- SLICE_WIDTH, 8, bits processed per clock; must be at least 5.
- NUM_SLICES, DATA_WIDTH/SLICE_WIDTH, derived; do not override.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- opcode  input  alu_op  ADD, ADC, SUB, SBC, INC or DEC; any other value is treated as a pass-through.
- a  input  DATA_WIDTH  operand A.
- b  input  DATA_WIDTH  operand B; ignored for INC/DEC.
- flags_in  input  8  current F register (S Z 5 H 3 PV N C, bit7..0).
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse when result/flags_out become valid.
- result  output  DATA_WIDTH  registered result; holds until the next accepted start.
- flags_out  output  8  registered flags; holds until the next accepted start.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - busy=0, done=0, result=0, flags_out=0, slice counter=0.
  - Internal operand/carry registers are cleared.
  - Reset during RUN abandons the operation; no done is produced.
- States:
  - IDLE: start=1 latches a, b, opcode and flags_in, sets carry_in, then goes to RUN with counter=0 and busy=1.
  - RUN: computes slice [counter], stores the result slice, chains the carry, and increments the counter.
    - On the cycle the counter reaches NUM_SLICES-1, the next state is DONE.
    - start is ignored throughout RUN; input changes have no effect after latching.
  - DONE: done=1 and busy=0 for exactly one cycle.
    - If start=1 in DONE, it is accepted (next state RUN), giving back-to-back operations.
    - Otherwise the next state is IDLE.
- Latency: with start accepted at edge k, done is high in the cycle following edge k+NUM_SLICES.
  - For the 16-bit default this is 2 compute cycles, with done visible after the 3rd edge.
- Arithmetic, modulo 2^DATA_WIDTH:
  - ADD: a+b, carry_in=0.
  - ADC: a+b+flags_in[0].
  - SUB: a-b (computed as a + ~b + 1).
  - SBC: a-b-flags_in[0].
  - INC: a+1.
  - DEC: a-1.
- Flags are computed over the full DATA_WIDTH result:
  - S = result[DATA_WIDTH-1].
  - Z = (result==0).
  - bit5 = result[DATA_WIDTH-3].
  - bit3 = result[DATA_WIDTH-5].
  - H = carry (add) or borrow (sub) out of bit DATA_WIDTH-5.
  - PV = two's-complement signed overflow.
  - N = 1 for SUB/SBC/DEC, else 0.
  - C = carry/borrow out of the MSB.
  - INC/DEC preserve C from flags_in[0]; all other flags update.
- Unsupported opcode: runs the full NUM_SLICES cycles, then result=a and flags_out=flags_in.
- H and PV are taken from the top slice only. The per-slice carry into bit DATA_WIDTH-4 and into the MSB must be captured when the top slice is computed.
- result and flags_out change only at the DONE transition; they are never partially updated while visible.

Test Plan:
- Reset release, then ADD a=16'h0007 b=16'h0007 -> done exactly 2 cycles after start is accepted; result=16'h000E, flags_out=8'h00; busy high for 2 cycles.
- ADD a=16'hABCD b=16'h0101 -> result=16'hACCE, flags_out=8'hA8.
- SUB 16'hABCD-16'hABCD -> 16'h0000, flags 8'h42. SUB 16'hABCD-16'hABCE -> 16'hFFFF, flags 8'hBB.
- INC a=16'hFFFF with flags_in=8'h01 -> 16'h0000, flags 8'h51 (C preserved). DEC a=16'h8000 with flags_in=8'h00 -> 16'h7FFF, flags 8'h3E (overflow).
- Handshake checks:
  - Pulse start again during RUN with different operands -> ignored; the first result is delivered.
  - start held high through DONE -> second operation begins with no IDLE gap.
  - rst_n low mid-RUN -> all outputs 0 and no done pulse.
- Parameter sweep DATA_WIDTH=8/16/32: random ADC/SBC vectors checked against a behavioural model -> results, flags and latency (NUM_SLICES) all match.
